// File: rtl/vga_pkg.sv
// vga_pkg: shared types, timing defaults and helpers for the VGA output stage.
//   pixel_t  - packed 24-bit pixel {r, g, b}
//   state_t  - stream alignment states
//   DEF_*    - 640x480@60 timing defaults
//   total()  - segment sum giving the total length of a line or frame
package vga_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ARMED    = 2'd1,
      RUN      = 2'd2
   } state_t;

   localparam int CNT_W        = 16;

   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;

   function automatic int total(input int sync, input int back, input int active,
                                input int front);
      return sync + back + active + front;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster counters and combinational position flags.
// Segment order in both dimensions is sync, back porch, active, front porch.
// Optional feature macro: VGA_TEST_PATTERN_EN (adds the colour-bar index output).
// Ports:
//   clk, rst_n - pixel clock, asynchronous active-low reset
//   hsync_n    - 0 while hcnt is inside the hsync pulse
//   vsync_n    - 0 while vcnt is inside the vsync pulse
//   active     - counters are inside the visible region
//   first      - counters are at the first visible pixel of the frame
//   bar        - colour-bar index of the current column (pattern builds only)
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT
)(
   input  logic       clk,
   input  logic       rst_n,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       active,
`ifdef VGA_TEST_PATTERN_EN
   output logic [2:0] bar,
`endif
   output logic       first
);

   localparam logic [CNT_W-1:0] H_LAST    = 16'(total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT) - 1);
   localparam logic [CNT_W-1:0] V_LAST    = 16'(total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT) - 1);
   localparam logic [CNT_W-1:0] H_SYNC_W  = 16'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_W  = 16'(V_SYNC);
   localparam logic [CNT_W-1:0] H_ACT_BEG = 16'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] H_ACT_END = 16'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_BEG = 16'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] V_ACT_END = 16'(V_SYNC + V_BACK + V_ACTIVE);

   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] vcnt;
   logic             h_act;
   logic             v_act;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 16'd1;
      end else begin
         hcnt <= hcnt + 16'd1;
      end
   end

   assign h_act   = (hcnt >= H_ACT_BEG) && (hcnt < H_ACT_END);
   assign v_act   = (vcnt >= V_ACT_BEG) && (vcnt < V_ACT_END);
   assign active  = h_act && v_act;
   assign first   = (hcnt == H_ACT_BEG) && (vcnt == V_ACT_BEG);
   assign hsync_n = (hcnt >= H_SYNC_W);
   assign vsync_n = (vcnt >= V_SYNC_W);

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [CNT_W-1:0] BAR_W = 16'(H_ACTIVE / 8);
   // Only meaningful inside the active region; the caller masks it elsewhere.
   assign bar = 3'((hcnt - H_ACT_BEG) / BAR_W);
`endif

endmodule

// File: rtl/vga_stream_out.sv
// vga_stream_out: VGA output stage. Generates raster timing, aligns an upstream
// valid/ready pixel stream (with start-of-frame marker) to the first visible
// pixel, and re-locks on the next SOF after an underflow.
// Optional feature macro: VGA_TEST_PATTERN_EN (adds pattern_sel, colour bars).
// Ports:
//   clk, rst_n            - pixel clock, asynchronous active-low reset
//   pattern_sel           - show colour bars, stall stream (pattern builds only)
//   in_valid/in_ready     - upstream handshake, transfer on both high at posedge
//   in_data, in_sof       - pixel {r,g,b} and start-of-frame marker
//   r, g, b, hsync, vsync - registered VGA outputs (syncs active low)
//   de, frame_start       - visible pixel, first visible pixel of a frame
//   locked                - stream aligned to the raster
//   underflow_cnt         - saturating underflow event count
//
// state    | meaning
// ---------+----------------------------------------------------------------
// WAIT_SOF | dropping pixels until one carries in_sof (that one is kept)
// ARMED    | SOF pixel held upstream, waiting for the first visible position
// RUN      | one pixel consumed per visible position
module vga_stream_out
   import vga_pkg::*;
#(
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT
)(
   input  logic        clk,
   input  logic        rst_n,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        pattern_sel,
`endif
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_data,
   input  logic        in_sof,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start,
   output logic        locked,
   output logic [15:0] underflow_cnt
);

   state_t state_q;
   state_t state_d;
   pixel_t pix_d;
   pixel_t pix_q;
   logic   take;
   logic   uf;
   logic   hsync_n;
   logic   vsync_n;
   logic   active;
   logic   first;
`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar;
`endif

   vga_timing #(
      .H_SYNC   (H_SYNC),
      .H_BACK   (H_BACK),
      .H_ACTIVE (H_ACTIVE),
      .H_FRONT  (H_FRONT),
      .V_SYNC   (V_SYNC),
      .V_BACK   (V_BACK),
      .V_ACTIVE (V_ACTIVE),
      .V_FRONT  (V_FRONT)
   ) u_timing (
      .clk     (clk),
      .rst_n   (rst_n),
      .hsync_n (hsync_n),
      .vsync_n (vsync_n),
      .active  (active),
`ifdef VGA_TEST_PATTERN_EN
      .bar     (bar),
`endif
      .first   (first)
   );

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      take     = 1'b0;
      uf       = 1'b0;
      pix_d    = '0;

      case (state_q)
         WAIT_SOF: begin
            // Accept and drop everything except the SOF pixel, which stays upstream.
            in_ready = !(in_valid && in_sof);
            if (in_valid && in_sof) state_d = ARMED;
         end
         ARMED: begin
            // The first visible position behaves like a RUN cycle.
            if (first) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  take    = 1'b1;
                  state_d = RUN;
               end else begin
                  uf      = 1'b1;
                  state_d = WAIT_SOF;
               end
            end
         end
         RUN: begin
            if (active) begin
               if (!in_valid) begin
                  in_ready = 1'b1;
                  uf       = 1'b1;
                  state_d  = WAIT_SOF;
               end else if (in_sof && !first) begin
                  // Early SOF: leave it upstream and wait for the raster to catch up.
                  state_d = ARMED;
               end else begin
                  // A missing SOF on the first pixel is tolerated: the stream owns framing.
                  in_ready = 1'b1;
                  take     = 1'b1;
               end
            end
         end
         default: state_d = WAIT_SOF;
      endcase

      if (take) pix_d = pixel_t'(in_data);

`ifdef VGA_TEST_PATTERN_EN
      if (pattern_sel) begin
         state_d  = state_q;
         in_ready = 1'b0;
         take     = 1'b0;
         uf       = 1'b0;
         pix_d    = '0;
         if (active) begin
            pix_d.r = {8{bar[2]}};
            pix_d.g = {8{bar[1]}};
            pix_d.b = {8{bar[0]}};
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT_SOF;
         pix_q         <= '0;
         hsync         <= 1'b0;
         vsync         <= 1'b0;
         de            <= 1'b0;
         frame_start   <= 1'b0;
         locked        <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         state_q     <= state_d;
         pix_q       <= pix_d;
         hsync       <= hsync_n;
         vsync       <= vsync_n;
         de          <= active;
         frame_start <= first;
         // Taken from the next state so lock lines up with the pixel it covers.
         locked      <= (state_d == RUN);
         if (uf && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
      end
   end

   assign r = pix_q.r;
   assign g = pix_q.g;
   assign b = pix_q.b;

endmodule
